mips_multicycle_core: RTL

Multi-cycle MIPS-I subset core that replaces the single-cycle datapath with a shared-memory, state-machine-sequenced implementation. A single memory port with a req/ack handshake serves both instruction fetch and data access, so the core tolerates wait states. The reset vector and the address width are parameters. Retire and halt status are exported for the SoC and for verification.

---
 rtl/mips_multicycle_core.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-I subset core: one req/ack memory port shared by fetch and data access,
// sequenced by a FETCH/DECODE/EXEC/MEM/WB/HALT state machine.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       pc,
  output logic              retire,
  output logic              halted
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_N = 32;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  logic [2:0]      r_state;
  logic [2:0]      w_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_npc;
  logic [XLEN-1:0] r_ir;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_aluout;
  logic [XLEN-1:0] r_mdr;
  logic [XLEN-1:0] r_rf [REG_N];

  logic [5:0]      w_op;
  logic [5:0]      w_funct;
  logic [4:0]      w_rs;
  logic [4:0]      w_rt;
  logic [4:0]      w_rd;
  logic [4:0]      w_shamt;
  logic [15:0]     w_imm16;
  logic [25:0]     w_target;
  logic            w_is_r;
  logic            w_is_mem;
  logic            w_is_br;
  logic            w_is_j;
  logic            w_is_jr;
  logic            w_legal;
  logic            w_br_taken;
  logic [XLEN-1:0] w_imm_ext;
  logic [XLEN-1:0] w_alu;
  logic [XLEN-1:0] w_addr_full;

  logic            w_req;
  logic            w_we;
  logic            w_retire;
  logic            w_pc_ld;
  logic [XLEN-1:0] w_pc_nxt;
  logic            w_rf_we;
  logic [4:0]      w_rf_wa;
  logic [XLEN-1:0] w_rf_wd;

  // Instruction field split; all later stages decode straight from IR.
  assign w_op       = r_ir[31:26];
  assign w_rs       = r_ir[25:21];
  assign w_rt       = r_ir[20:16];
  assign w_rd       = r_ir[15:11];
  assign w_shamt    = r_ir[10:6];
  assign w_funct    = r_ir[5:0];
  assign w_imm16    = r_ir[15:0];
  assign w_target   = r_ir[25:0];
  assign w_is_r     = (w_op == OP_RTYPE);
  assign w_is_mem   = (w_op == OP_LW) || (w_op == OP_SW);
  assign w_is_br    = (w_op == OP_BEQ) || (w_op == OP_BNE);
  assign w_is_j     = (w_op == OP_J) || (w_op == OP_JAL);
  assign w_is_jr    = w_is_r && (w_funct == F_JR);
  assign w_br_taken = (w_op == OP_BEQ) ? (r_a == r_b) : (r_a != r_b);

  always_comb begin
    w_legal = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        case (w_funct)
          F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL, F_SRL, F_JR: w_legal = 1'b1;
          default: w_legal = 1'b0;
        endcase
      end
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
      OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  // Logical immediates zero-extend, lui pre-shifts, everything else sign-extends.
  always_comb begin
    case (w_op)
      OP_ANDI, OP_ORI: w_imm_ext = {16'h0000, w_imm16};
      OP_LUI:          w_imm_ext = {w_imm16, 16'h0000};
      default:         w_imm_ext = {{16{w_imm16[15]}}, w_imm16};
    endcase
  end

  always_comb begin
    w_alu = '0;
    if (w_is_r) begin
      case (w_funct)
        F_ADD:   w_alu = r_a + r_b;
        F_SUB:   w_alu = r_a - r_b;
        F_AND:   w_alu = r_a & r_b;
        F_OR:    w_alu = r_a | r_b;
        F_SLT:   w_alu = {31'd0, ($signed(r_a) < $signed(r_b))};
        F_SLL:   w_alu = r_b << w_shamt;
        F_SRL:   w_alu = r_b >> w_shamt;
        default: w_alu = '0;
      endcase
    end else begin
      case (w_op)
        OP_ADDI, OP_LW, OP_SW: w_alu = r_a + r_imm;
        OP_SLTI: w_alu = {31'd0, ($signed(r_a) < $signed(r_imm))};
        OP_ANDI: w_alu = r_a & r_imm;
        OP_ORI:  w_alu = r_a | r_imm;
        OP_LUI:  w_alu = r_imm;
        default: w_alu = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_req    = 1'b0;
    w_we     = 1'b0;
    w_retire = 1'b0;
    w_pc_ld  = 1'b0;
    w_pc_nxt = r_npc;
    w_rf_we  = 1'b0;
    w_rf_wa  = 5'd0;
    w_rf_wd  = r_aluout;
    case (r_state)
      S_FETCH: begin
        w_req = 1'b1;
        if (mem_ack) w_next = S_DECODE;
      end
      S_DECODE: w_next = w_legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (w_is_mem) begin
          w_next = (w_alu[1:0] != 2'b00) ? S_HALT : S_MEM;
        end else if (w_is_br) begin
          w_pc_ld  = 1'b1;
          w_retire = 1'b1;
          w_next   = S_FETCH;
          if (w_br_taken) w_pc_nxt = r_npc + (r_imm << 2);
        end else if (w_is_j) begin
          w_pc_ld  = 1'b1;
          w_retire = 1'b1;
          w_next   = S_FETCH;
          w_pc_nxt = {r_npc[31:28], w_target, 2'b00};
          if (w_op == OP_JAL) begin
            w_rf_we = 1'b1;
            w_rf_wa = 5'd31;
            w_rf_wd = r_npc;
          end
        end else if (w_is_jr) begin
          // A misaligned jump target would produce a misaligned fetch.
          if (r_a[1:0] != 2'b00) begin
            w_next = S_HALT;
          end else begin
            w_pc_ld  = 1'b1;
            w_retire = 1'b1;
            w_pc_nxt = r_a;
            w_next   = S_FETCH;
          end
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        w_req = 1'b1;
        w_we  = (w_op == OP_SW);
        if (mem_ack) begin
          if (w_op == OP_SW) begin
            w_retire = 1'b1;
            w_pc_ld  = 1'b1;
            w_next   = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end
      end
      S_WB: begin
        w_rf_we  = 1'b1;
        w_rf_wa  = w_is_r ? w_rd : w_rt;
        w_rf_wd  = (w_op == OP_LW) ? r_mdr : r_aluout;
        w_retire = 1'b1;
        w_pc_ld  = 1'b1;
        w_next   = S_FETCH;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_HALT;
    endcase
  end

  // Datapath registers and register file; $0 is never written so it always reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_npc    <= '0;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_imm    <= '0;
      r_aluout <= '0;
      r_mdr    <= '0;
      for (int i = 0; i < REG_N; i++) r_rf[i] <= '0;
    end else begin
      if (r_state == S_FETCH && mem_ack) begin
        r_ir  <= mem_rdata;
        r_npc <= r_pc + 32'd4;
      end
      if (r_state == S_DECODE) begin
        r_a   <= r_rf[w_rs];
        r_b   <= r_rf[w_rt];
        r_imm <= w_imm_ext;
      end
      if (r_state == S_EXEC) r_aluout <= w_alu;
      if (r_state == S_MEM && mem_ack && w_op == OP_LW) r_mdr <= mem_rdata;
      if (w_pc_ld) r_pc <= w_pc_nxt;
      if (w_rf_we && w_rf_wa != 5'd0) r_rf[w_rf_wa] <= w_rf_wd;
    end
  end

  // Reset forces the bus idle immediately, before the state register is cleared.
  assign w_addr_full = (r_state == S_MEM) ? r_aluout : r_pc;
  assign mem_req     = w_req & ~rst;
  assign mem_we      = w_we & ~rst;
  assign mem_addr    = ADDR_W'(w_addr_full);
  assign mem_wdata   = r_b;
  assign pc          = rst ? RESET_PC : r_pc;
  assign retire      = w_retire & ~rst;
  assign halted      = (r_state == S_HALT) & ~rst;

endmodule
